// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: word width, NOP encoding and
// the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, issues req/ready fetches and turns a taken
// branch into a PC redirect plus a one-cycle flush.
//
// state | meaning
// IDLE  | out of reset, no request issued
// FETCH | requesting at pc, filling the single output slot
// DROP  | redirect arrived mid-request; draining old response, then jump to pend_pc
module fetch_redirect_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            flush
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic [XLEN-1:0] instr_n, instr_pc_n;
  logic            instr_valid_n, flush_n;
  logic [XLEN-1:0] target_aligned;
  logic            done;

  assign target_aligned = {br_target[XLEN-1:2], 2'b00};

  // Request depends only on registered state and stall, never on imem_ready.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = !instr_valid || !stall;
      DROP:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc;
  assign done      = imem_req && imem_ready;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_pc_n     = pend_pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    flush_n       = 1'b0;

    case (state)
      IDLE: begin
        state_n = FETCH;
        if (br) begin
          flush_n       = 1'b1;
          instr_valid_n = 1'b0;
          pc_n          = target_aligned;
        end
      end

      FETCH: begin
        if (br) begin
          flush_n       = 1'b1;
          instr_valid_n = 1'b0;
          if (imem_req && !imem_ready) begin
            pend_pc_n = target_aligned;
            state_n   = DROP;
          end else begin
            pc_n = target_aligned;
          end
        end else if (done) begin
          instr_n       = imem_rdata;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          pc_n          = pc + 32'd4;
        end else if (instr_valid && !stall) begin
          instr_valid_n = 1'b0;
        end
      end

      DROP: begin
        instr_valid_n = 1'b0;
        if (br) begin
          flush_n   = 1'b1;
          pend_pc_n = target_aligned;
        end
        // A branch coinciding with the drain wins over the older pending target.
        if (imem_ready) begin
          pc_n    = br ? target_aligned : pend_pc;
          state_n = FETCH;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_pc     <= pend_pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      flush       <= flush_n;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a combinational memory whose
// data is the bitwise inverse of the address.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        flush;

  int total  = 0;
  int passed = 0;

  fetch_redirect_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .br         (br),
    .br_target  (br_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; br_target = '0; stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_instr", instr,                32'h0000_0013);
    chk("rst_ipc",   instr_pc,             32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush},       32'd0);

    // Reset release, zero-wait memory from 0x100
    rst = 1'b0;
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("f0_req",   {31'd0, imem_req},    32'd1);
    chk("f0_addr",  imem_addr,            32'h100);
    chk("f0_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("f1_addr",  imem_addr,            32'h104);
    chk("f1_valid", {31'd0, instr_valid}, 32'd1);
    chk("f1_ipc",   instr_pc,             32'h100);
    chk("f1_instr", instr,                ~32'h100);
    tick();
    chk("f2_addr", imem_addr, 32'h108);
    chk("f2_ipc",  instr_pc,  32'h104);

    // Stall three cycles with a live instruction
    stall = 1'b1;
    #1 chk("st_req0", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_req",   {31'd0, imem_req},    32'd0);
      chk("st_ipc",   instr_pc,             32'h104);
      chk("st_instr", instr,                ~32'h104);
      chk("st_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    #1 chk("st_rel_addr", imem_addr, 32'h108);
    tick();
    chk("st_res_ipc", instr_pc, 32'h108);

    // Redirect with zero-wait memory; target low bits dropped
    br = 1'b1; br_target = 32'h2003;
    tick();
    br = 1'b0;
    chk("br_flush", {31'd0, flush},       32'd1);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_addr",  imem_addr,            32'h2000);
    tick();
    chk("br_flush_end", {31'd0, flush},       32'd0);
    chk("br_new_valid", {31'd0, instr_valid}, 32'd1);
    chk("br_new_ipc",   instr_pc,             32'h2000);

    // Redirect to 0x40, then a branch while 0x40 is wait-stated
    br = 1'b1; br_target = 32'h40;
    tick();
    chk("w_addr0", imem_addr, 32'h40);
    imem_ready = 1'b0; br_target = 32'h800;
    tick();
    br = 1'b0;
    chk("w_flush", {31'd0, flush},       32'd1);
    chk("w_req",   {31'd0, imem_req},    32'd1);
    chk("w_addr1", imem_addr,            32'h40);
    chk("w_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("w_addr2",  imem_addr,            32'h40);
    chk("w_valid2", {31'd0, instr_valid}, 32'd0);
    chk("w_flush2", {31'd0, flush},       32'd0);
    imem_ready = 1'b1;
    tick();
    chk("w_tgt_addr", imem_addr,            32'h800);
    chk("w_discard",  {31'd0, instr_valid}, 32'd0);
    tick();
    chk("w_tgt_ipc", instr_pc, 32'h800);

    // Two further branches while draining
    imem_ready = 1'b0; br = 1'b1; br_target = 32'h400;
    tick();
    chk("d_flush0", {31'd0, flush}, 32'd1);
    br_target = 32'h500;
    tick();
    br = 1'b0;
    chk("d_flush1", {31'd0, flush}, 32'd1);
    chk("d_addr",   imem_addr,      32'h804);
    tick();
    chk("d_gap", {31'd0, flush}, 32'd0);
    br = 1'b1; br_target = 32'h600;
    tick();
    br = 1'b0;
    chk("d_flush2", {31'd0, flush},       32'd1);
    chk("d_valid",  {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("d_tgt_addr", imem_addr,      32'h600);
    chk("d_flush3",   {31'd0, flush}, 32'd0);

    // PC wrap at the top of the address space
    br = 1'b1; br_target = 32'hFFFF_FFFF;
    tick();
    br = 1'b0;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_ipc",  instr_pc,  32'hFFFF_FFFC);
    chk("wr_addr", imem_addr, 32'h0000_0000);

    // Reset in the middle of a wait-stated request
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ar_req",   {31'd0, imem_req},    32'd0);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_addr",  imem_addr,            32'h100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch front end that consumes the registered branch/jump decision `br` and its target, and turns it into a PC redirect plus a pipeline flush. It owns the program counter, issues fetch requests to instruction memory over a req/ready handshake, and presents one fetched instruction at a time to decode. It handles redirects that arrive while a fetch is still outstanding by draining the in-flight response before switching address.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `br`  in  1  taken branch/jump pulse from the branch unit (registered, one cycle).
- `br_target`  in  32  redirect address, valid when `br`=1; bits [1:0] ignored (forced to 0).
- `stall`  in  1  decode cannot accept; hold current instruction.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory completes current request this cycle.
- `imem_rdata`  in  32  instruction data, valid when `imem_req & imem_ready`.
- `instr`  out  32  instruction to decode.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr` is live.
- `flush`  out  1  one-cycle squash of younger in-flight instructions.

## Operation
- States: IDLE, FETCH, DROP.
- IDLE: entered on reset; `imem_req`=0; moves to FETCH on the first clock edge after reset deasserts.
- FETCH: `imem_req` = `!instr_valid | !stall`; `imem_addr` = `pc`.
  - Handshake completes (`imem_req & imem_ready`) with `br`=0: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `instr_valid`<=1, `pc`<=`pc`+4.
  - `instr_valid`=1, `stall`=0, no completion: `instr_valid`<=0 (slot consumed).
  - `stall`=1 with `instr_valid`=1: outputs held, no request.
- Memory rule: once `imem_req`=1 without `imem_ready`, `imem_addr` stays stable and `imem_req` stays high until `imem_ready`.
- Redirect (`br`=1). Priority: `rst` > `br` > handshake/`stall`.
  - Always: `instr_valid`<=0, `flush`<=1 next cycle.
  - In FETCH with no pending request, or with completion the same cycle: data discarded, `pc`<={`br_target`[31:2],2'b00}, stay FETCH.
  - In FETCH with request pending and `imem_ready`=0: `pend_pc`<=target, go DROP.
- DROP: `imem_req`=1 at old `pc`. On `imem_ready`, data discarded, `pc`<=`pend_pc`, go FETCH. A further `br` in DROP overwrites `pend_pc` and re-pulses `flush`. `instr_valid` stays 0 throughout.
- `pc` wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_pc`=0, `instr_valid`=0, `flush`=0, `imem_req`=0, state IDLE, `pend_pc`=0.
- Fetch latency: `instr_valid` rises the edge after the handshake; zero-wait memory sustains one instruction per cycle.
- `flush` is registered: high exactly one cycle, the cycle after `br` is sampled.
- Redirect-to-request latency: `imem_addr`=target the cycle after `br` (FETCH case), or the cycle after the drained `imem_ready` (DROP case).
- `imem_req`/`imem_addr` are combinational from state, `pc` and `instr_valid`/`stall` only; no path from `imem_ready` or `imem_rdata`.
- Reset mid-DROP or mid-wait: request dropped immediately; the memory model must tolerate an abandoned request.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR` (32'h0000_0013), `XLEN`=32, fetch state enum {IDLE, FETCH, DROP}.
- Single module; FSM, `pc`/`pend_pc` registers and output slot are inline. No sub-module.

## Test plan
- Reset release, zero-wait memory, `RESET_PC`=0x100: `imem_addr` sequence 0x100, 0x104, 0x108; `instr_valid` high from the 3rd cycle; `instr_pc` tracks.
- `stall`=1 for 3 cycles with `instr_valid`=1: `imem_req`=0, `instr`/`instr_pc` held; resumes at next address when released.
- `br`=1, target 0x2003, zero-wait memory: `flush`=1 one cycle; next `imem_addr`=0x2000; no instruction from the old path becomes valid.
- `br` while memory wait-stated 3 cycles at 0x40: `imem_addr` held 0x40 until `imem_ready`, data discarded, next request at target; `instr_valid`=0 throughout.
- Two `br` pulses in DROP (targets 0x500, 0x600): `flush` pulses twice; first post-drain request at 0x600.
- `pc`=0xFFFF_FFFC fetched: next `imem_addr`=0x0000_0000.
